// File: rtl/par_int_rx_fifo.sv
// ============================================================================
// Module   : par_int_rx_fifo
// Brief    : Single-clock receive FIFO for an 8-bit parallel write interface,
//            registered one-cycle-latency read port, registered full/empty.
//            Optional sticky overflow/underflow flags: define PAR_FIFO_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module par_int_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_dout_vld,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
`ifdef PAR_FIFO_ERR_EN
    ,
    output logic             o_ovf,
    output logic             o_udf
`endif
);

    localparam int            PW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] c_DEPTH_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_vld;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [CW-1:0]    w_count_nxt;

    // Acceptance uses the registered flags, so a full FIFO still takes a
    // read and an empty FIFO still takes a write on a simultaneous request.
    always_comb begin
        w_wr_acc    = i_wr_en & ~r_full;
        w_rd_acc    = i_rd_en & ~r_empty;
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_dout   <= r_mem[r_rd_ptr];
            end
            r_dout_vld <= w_rd_acc;
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == c_DEPTH_CNT);
            r_empty    <= (w_count_nxt == '0);
        end
    end

`ifdef PAR_FIFO_ERR_EN
    logic r_ovf;
    logic r_udf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (i_wr_en && r_full) begin
                r_ovf <= 1'b1;
            end
            if (i_rd_en && r_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign o_ovf = r_ovf;
    assign o_udf = r_udf;
`endif

    assign o_dout     = r_dout;
    assign o_dout_vld = r_dout_vld;
    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_par_int_rx_fifo.sv
// ============================================================================
// Module   : tb_par_int_rx_fifo
// Brief    : Self-checking bench for par_int_rx_fifo (queue reference model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_par_int_rx_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic             clk;
    logic             rst_n;
    logic             i_wr_en;
    logic [WIDTH-1:0] i_din;
    logic             i_rd_en;
    logic [WIDTH-1:0] o_dout;
    logic             o_dout_vld;
    logic             o_full;
    logic             o_empty;
    logic [CW-1:0]    o_count;
`ifdef PAR_FIFO_ERR_EN
    logic             o_ovf;
    logic             o_udf;
`endif

    par_int_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (i_wr_en),
        .i_din      (i_din),
        .i_rd_en    (i_rd_en),
        .o_dout     (o_dout),
        .o_dout_vld (o_dout_vld),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_count    (o_count)
`ifdef PAR_FIFO_ERR_EN
        ,
        .o_ovf      (o_ovf),
        .o_udf      (o_udf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: an ordered queue of stored words plus output state.
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_vld;
    logic             m_ovf;
    logic             m_udf;

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic       rd;
        int         exp_count;
        logic       exp_vld;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dout = '0;
        m_vld  = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic compare_model(input string tag);
        chk({tag, "_count"}, 32'(o_count), 32'(m_q.size()));
        chk({tag, "_empty"}, 32'(o_empty), 32'(m_q.size() == 0));
        chk({tag, "_full"},  32'(o_full),  32'(m_q.size() == DEPTH));
        chk({tag, "_vld"},   32'(o_dout_vld), 32'(m_vld));
        chk({tag, "_dout"},  32'(o_dout),  32'(m_dout));
`ifdef PAR_FIFO_ERR_EN
        chk({tag, "_ovf"},   32'(o_ovf),   32'(m_ovf));
        chk({tag, "_udf"},   32'(o_udf),   32'(m_udf));
`endif
    endtask

    // One clock: drive, advance the model on the edge, compare 1 time unit later.
    task automatic cycle(input logic wr, input logic [7:0] din, input logic rd, input string tag);
        bit was_full;
        bit was_empty;
        i_wr_en = wr;
        i_din   = din;
        i_rd_en = rd;
        @(posedge clk);
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        if (wr && was_full) m_ovf = 1'b1;
        if (rd && was_empty) m_udf = 1'b1;
        if (rd && !was_empty) begin
            m_dout = m_q.pop_front();
            m_vld  = 1'b1;
        end else begin
            m_vld = 1'b0;
        end
        if (wr && !was_full) m_q.push_back(din);
        #1;
        compare_model(tag);
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got[$];
        logic [7:0] nxt;
        int         iter;
        int         sel;

        // Directed table: basic order, empty read, simultaneous ops at 0 and 3.
        vecs[0]  = '{1'b1, 8'hD6, 1'b0, 1, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 8'h3C, 1'b0, 2, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 8'hFF, 1'b0, 3, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 2, 1'b1, 8'hD6};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h3C};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'hFF};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 8'hFF};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'hFF};
        vecs[8]  = '{1'b1, 8'h11, 1'b1, 1, 1'b0, 8'hFF};
        vecs[9]  = '{1'b1, 8'h22, 1'b0, 2, 1'b0, 8'hFF};
        vecs[10] = '{1'b1, 8'h33, 1'b0, 3, 1'b0, 8'hFF};
        vecs[11] = '{1'b1, 8'h44, 1'b1, 3, 1'b1, 8'h11};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 2, 1'b1, 8'h22};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h33};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h44};

        rst_n   = 1'b0;
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
        i_din   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full",  32'(o_full),  32'd0);
        chk("rst_vld",   32'(o_dout_vld), 32'd0);
        chk("rst_dout",  32'(o_dout),  32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].wr, vecs[i].din, vecs[i].rd, "tbl");
            chk("tbl_count", 32'(o_count), 32'(vecs[i].exp_count));
            chk("tbl_vld",   32'(o_dout_vld), 32'(vecs[i].exp_vld));
            chk("tbl_dout",  32'(o_dout), 32'(vecs[i].exp_dout));
        end
`ifdef PAR_FIFO_ERR_EN
        chk("udf_sticky", 32'(o_udf), 32'd1);
`endif

        // Fill to full, reject a write, then simultaneous op at full.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, "fill");
        chk("fill_full",  32'(o_full),  32'd1);
        chk("fill_count", 32'(o_count), 32'(DEPTH));
        cycle(1'b1, 8'hAA, 1'b0, "ovf");
        chk("ovf_count", 32'(o_count), 32'(DEPTH));
`ifdef PAR_FIFO_ERR_EN
        chk("ovf_flag", 32'(o_ovf), 32'd1);
`endif
        cycle(1'b1, 8'hBB, 1'b1, "wrrd_full");
        chk("wrrd_full_count", 32'(o_count), 32'(DEPTH - 1));
        chk("wrrd_full_dout",  32'(o_dout),  32'h00);
        for (int i = 1; i < DEPTH; i++) begin
            cycle(1'b0, 8'h00, 1'b1, "drain");
            chk("drain_dout", 32'(o_dout), 32'(i));
        end
        chk("drain_empty", 32'(o_empty), 32'd1);

        // Interleaved stream 0x10..0x23 holding occupancy within 2..6.
        got.delete();
        nxt  = 8'h10;
        iter = 0;
        while (got.size() < 20 && iter < 400) begin
            bit can_wr;
            bit can_rd;
            can_wr = (nxt <= 8'h23) && (m_q.size() < 6);
            can_rd = (m_q.size() > 2) || ((nxt > 8'h23) && (m_q.size() > 0));
            if (m_q.size() < 2 && nxt <= 8'h23) can_rd = 1'b0;
            sel = 32'($urandom_range(0, 2));
            if (can_wr && can_rd) begin
                cycle(sel != 1, nxt, sel != 0, "ilv");
                if (sel != 1) nxt++;
            end else if (can_wr) begin
                cycle(1'b1, nxt, 1'b0, "ilv");
                nxt++;
            end else begin
                cycle(1'b0, 8'h00, 1'b1, "ilv");
            end
            if (o_dout_vld) got.push_back(o_dout);
            iter++;
        end
        chk("ilv_len", 32'(got.size()), 32'd20);
        for (int i = 0; i < 20 && i < got.size(); i++) begin
            chk("ilv_seq", 32'(got[i]), 32'h10 + 32'(i));
        end

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), "rnd");
        end

        // Asynchronous reset mid-period with five words stored.
        while (m_q.size() > 0) cycle(1'b0, 8'h00, 1'b1, "pre");
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0, "pre");
        cycle(1'b0, 8'h00, 1'b1, "pre");
        chk("pre_count", 32'(o_count), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_count", 32'(o_count), 32'd0);
        chk("arst_empty", 32'(o_empty), 32'd1);
        chk("arst_vld",   32'(o_dout_vld), 32'd0);
        chk("arst_dout",  32'(o_dout),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 8'h5A, 1'b0, "post");
        cycle(1'b0, 8'h00, 1'b1, "post");
        chk("post_dout", 32'(o_dout), 32'h5A);
        cycle(1'b0, 8'h00, 1'b1, "post");
        chk("post_vld", 32'(o_dout_vld), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
